max_scan_ctrl: RTL and testbench



---
 rtl/max_scan_ctrl_if.sv | 25 ++
 rtl/max_scan_ctrl.sv | 88 ++++++++
 tb/tb_max_scan_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/max_scan_ctrl_if.sv
// Bus between the max-scan controller and its mux/consumer.
// master = controller side, slave = mux and result consumer side.
interface max_scan_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int SEL_W  = 4
);
   logic              en;
   logic              start;
   logic [DATA_W-1:0] din;
   logic [SEL_W-1:0]  sel;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] max_val;
   logic [SEL_W-1:0]  max_idx;

   modport master (
      input  en, start, din,
      output sel, busy, done, max_val, max_idx
   );

   modport slave (
      output en, start, din,
      input  sel, busy, done, max_val, max_idx
   );
endinterface

// File: rtl/max_scan_ctrl.sv
// Sweeps the mux select over N_IN inputs and tracks the running max and its index.
// Define MAX_SCAN_SIGNED_EN for two's-complement comparison; unsigned otherwise.
module max_scan_ctrl #(
   parameter int DATA_W = 16,
   parameter int N_IN   = 16,
   parameter int SEL_W  = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   max_scan_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DONE
   } state_t;

   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_IN - 1);

   state_t            r_state;
   logic [SEL_W-1:0]  r_sel;
   logic              r_busy;
   logic              r_done;
   logic [DATA_W-1:0] r_max_val;
   logic [SEL_W-1:0]  r_max_idx;
   logic              w_greater;

`ifdef MAX_SCAN_SIGNED_EN
   assign w_greater = $signed(bus.din) > $signed(r_max_val);
`else
   assign w_greater = bus.din > r_max_val;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_sel     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_max_val <= '0;
         r_max_idx <= '0;
      end else if (bus.en) begin
         case (r_state)
            ST_IDLE: begin
               r_sel  <= '0;
               r_done <= 1'b0;
               if (bus.start) begin
                  r_state <= ST_SCAN;
                  r_busy  <= 1'b1;
               end
            end
            ST_SCAN: begin
               // Index 0 seeds the result; later strict-greater keeps the lowest index on ties.
               if (r_sel == '0 || w_greater) begin
                  r_max_val <= bus.din;
                  r_max_idx <= r_sel;
               end
               if (r_sel == LAST_SEL) begin
                  r_sel   <= '0;
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_sel <= r_sel + SEL_W'(1);
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_sel   <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sel     = r_sel;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.max_val = r_max_val;
   assign bus.max_idx = r_max_idx;

endmodule

// File: tb/tb_max_scan_ctrl.sv
// Scoreboard bench for max_scan_ctrl: stimulus pushes expected results, a monitor checks each done pulse.
module tb_max_scan_ctrl;
   localparam int DATA_W = 16;
   localparam int N_IN   = 16;
   localparam int SEL_W  = 4;

   typedef struct {
      logic [DATA_W-1:0] val;
      logic [SEL_W-1:0]  idx;
      int                cyc;
      string             name;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic [DATA_W-1:0] data [N_IN];
   exp_t exp_q [$];
   logic prev_done = 1'b0;
   logic chk_after_done = 1'b0;

   max_scan_ctrl_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

   max_scan_ctrl #(.DATA_W(DATA_W), .N_IN(N_IN), .SEL_W(SEL_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign bus.din = data[bus.sel];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare on each rising done, then confirm busy/done drop one cycle later.
   always @(negedge clk) begin
      if (chk_after_done && bus.en) begin
         chk_after_done <= 1'b0;
         check("busy_after_done", {31'b0, bus.busy}, 32'd0);
         check("done_one_cycle", {31'b0, bus.done}, 32'd0);
      end
      if (bus.done && !prev_done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("done %s: max_val=0x%04h max_idx=%0d cycle=%0d", e.name, bus.max_val, bus.max_idx, cyc);
            check({e.name, "_max_val"}, 32'(bus.max_val), 32'(e.val));
            check({e.name, "_max_idx"}, 32'(bus.max_idx), 32'(e.idx));
            check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
            chk_after_done <= 1'b1;
         end
      end
      prev_done <= bus.done;
   end

   task automatic push(input logic [DATA_W-1:0] v, input logic [SEL_W-1:0] i, input int c, input string n);
      exp_t e;
      e.val = v; e.idx = i; e.cyc = c; e.name = n;
      exp_q.push_back(e);
   endtask

   task automatic pulse_start(input logic [DATA_W-1:0] v, input logic [SEL_W-1:0] i, input int stalls, input string n);
      push(v, i, cyc + 17 + stalls, n);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input string n);
      int t = 0;
      while ((exp_q.size() != 0 || bus.busy) && t < 200) begin
         tick();
         t++;
      end
      if (t >= 200) check({n, "_timeout"}, 32'd1, 32'd0);
      tick();
      tick();
   endtask

   initial begin
      int c0;
      bus.en = 1'b1;
      bus.start = 1'b0;
      for (int k = 0; k < N_IN; k++) data[k] = DATA_W'(k);

      // Reset state
      rst_n = 1'b0;
      tick(); tick();
      check("rst_sel", 32'(bus.sel), 32'd0);
      check("rst_busy", {31'b0, bus.busy}, 32'd0);
      check("rst_done", {31'b0, bus.done}, 32'd0);
      check("rst_max_val", 32'(bus.max_val), 32'd0);
      check("rst_max_idx", 32'(bus.max_idx), 32'd0);
      rst_n = 1'b1;
      tick();

      // Ramp: sel steps 0..15 on consecutive cycles
      pulse_start(16'd15, 4'd15, 0, "ramp");
      check("ramp_busy", {31'b0, bus.busy}, 32'd1);
      for (int k = 0; k < N_IN; k++) begin
         check($sformatf("ramp_sel%0d", k), 32'(bus.sel), 32'(k));
         tick();
      end
      wait_idle("ramp");

      // All equal: tie keeps index 0
      for (int k = 0; k < N_IN; k++) data[k] = 16'h0042;
      pulse_start(16'h0042, 4'd0, 0, "equal");
      wait_idle("equal");

      // Sign-sensitive value at index 5
      for (int k = 0; k < N_IN; k++) data[k] = DATA_W'(k);
      data[5] = 16'h8000;
`ifdef MAX_SCAN_SIGNED_EN
      pulse_start(16'd15, 4'd15, 0, "sign");
`else
      pulse_start(16'h8000, 4'd5, 0, "sign");
`endif
      wait_idle("sign");

      // en=0 for 3 cycles while sel=7
      data[5] = 16'd5;
      c0 = cyc;
      pulse_start(16'd15, 4'd15, 3, "stall");
      while (cyc < c0 + 8) tick();
      check("stall_sel_pre", 32'(bus.sel), 32'd7);
      bus.en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("stall_sel_hold%0d", k), 32'(bus.sel), 32'd7);
      end
      bus.en = 1'b1;
      wait_idle("stall");

      // Reset mid-scan at sel=9 aborts without done
      c0 = cyc;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      while (cyc < c0 + 10) tick();
      check("abort_sel_pre", 32'(bus.sel), 32'd9);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_busy", {31'b0, bus.busy}, 32'd0);
      check("abort_sel", 32'(bus.sel), 32'd0);
      check("abort_max_val", 32'(bus.max_val), 32'd0);
      check("abort_max_idx", 32'(bus.max_idx), 32'd0);
      check("abort_done", {31'b0, bus.done}, 32'd0);
      for (int k = 0; k < 20; k++) tick();
      pulse_start(16'd15, 4'd15, 0, "after_abort");
      wait_idle("after_abort");

      // start held: done every 18 cycles, d_k = 15-k
      for (int k = 0; k < N_IN; k++) data[k] = DATA_W'(15 - k);
      c0 = cyc;
      push(16'd15, 4'd0, c0 + 17, "held0");
      push(16'd15, 4'd0, c0 + 35, "held1");
      push(16'd15, 4'd0, c0 + 53, "held2");
      bus.start = 1'b1;
      while (cyc < c0 + 54) tick();
      bus.start = 1'b0;
      wait_idle("held");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
